// File: rtl/cache_set_assoc_if.sv
// -----------------------------------------------------------------------------
// cache_set_assoc_if
// Bus between the cache controller (master) and one set-associative cache set
// (slave).
//   Lookup ports : rdAddr/rd2Addr in; rdData/rdHit/rdWay, rd2Data/rd2Hit/rd2Way out
//   Victim       : victimWay/victimValid/victimDirty/victimTag out
//   Write port   : write, wrWay, wrOff, wrTag, wrValid, wrDirty, wrData,
//                  wrByteEnable in; lkupData out (write-back readout)
//   LRU/control  : touch, touchWay, inval in
// -----------------------------------------------------------------------------
interface cache_set_assoc_if #(
  parameter int CACHE_LINE_WIDTH = 6,
  parameter int TAG_WIDTH        = 20,
  parameter int ADDR_WIDTH       = 32,
  parameter int WAY_BITS         = 2
);
  logic [ADDR_WIDTH-1:0]       rdAddr;
  logic [31:0]                 rdData;
  logic                        rdHit;
  logic [WAY_BITS-1:0]         rdWay;
  logic [ADDR_WIDTH-1:0]       rd2Addr;
  logic [31:0]                 rd2Data;
  logic                        rd2Hit;
  logic [WAY_BITS-1:0]         rd2Way;
  logic [WAY_BITS-1:0]         victimWay;
  logic                        victimValid;
  logic                        victimDirty;
  logic [TAG_WIDTH-1:0]        victimTag;
  logic                        write;
  logic [WAY_BITS-1:0]         wrWay;
  logic [CACHE_LINE_WIDTH-1:0] wrOff;
  logic [TAG_WIDTH-1:0]        wrTag;
  logic                        wrValid;
  logic                        wrDirty;
  logic [31:0]                 wrData;
  logic [3:0]                  wrByteEnable;
  logic [31:0]                 lkupData;
  logic                        touch;
  logic [WAY_BITS-1:0]         touchWay;
  logic                        inval;

  modport master (
    output rdAddr, rd2Addr, write, wrWay, wrOff, wrTag, wrValid, wrDirty,
           wrData, wrByteEnable, touch, touchWay, inval,
    input  rdData, rdHit, rdWay, rd2Data, rd2Hit, rd2Way, victimWay,
           victimValid, victimDirty, victimTag, lkupData
  );

  modport slave (
    input  rdAddr, rd2Addr, write, wrWay, wrOff, wrTag, wrValid, wrDirty,
           wrData, wrByteEnable, touch, touchWay, inval,
    output rdData, rdHit, rdWay, rd2Data, rd2Hit, rd2Way, victimWay,
           victimValid, victimDirty, victimTag, lkupData
  );
endinterface

// File: rtl/cache_set_assoc.sv
// -----------------------------------------------------------------------------
// cache_set_assoc
// One set of an N-way set-associative cache: per way a tag, valid and dirty
// bit and a line of 32-bit words, plus true-LRU age counters.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears all state)
//   bus   : cache_set_assoc_if.slave -- two combinational lookup ports, victim
//           selection, byte-enabled write port with write-back readout,
//           LRU touch and bulk invalidate.
// Lookups and victim outputs are combinational views of registered state;
// writes, LRU updates and invalidates take effect on the next clock edge.
// -----------------------------------------------------------------------------
module cache_set_assoc #(
  parameter int CACHE_LINE_WIDTH = 6,
  parameter int TAG_WIDTH        = 20,
  parameter int ADDR_WIDTH       = 32,
  parameter int NUM_WAYS         = 4,
  parameter int WAY_BITS         = 2
) (
  input logic             clk,
  input logic             rst_n,
  cache_set_assoc_if.slave bus
);

  localparam int WORD_IDX_W = CACHE_LINE_WIDTH - 2;
  localparam int NUM_WORDS  = 1 << WORD_IDX_W;
  localparam int TAG_LSB    = ADDR_WIDTH - TAG_WIDTH;

  // Registered set state
  logic [TAG_WIDTH-1:0] tag_r   [NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_r;
  logic [NUM_WAYS-1:0]  dirty_r;
  logic [31:0]          data_r  [NUM_WAYS][NUM_WORDS];
  logic [WAY_BITS-1:0]  age_r   [NUM_WAYS];

  // Combinational views
  logic                  rd_hit_s;
  logic [WAY_BITS-1:0]   rd_way_s;
  logic [31:0]           rd_data_s;
  logic                  rd2_hit_s;
  logic [WAY_BITS-1:0]   rd2_way_s;
  logic [31:0]           rd2_data_s;
  logic [WAY_BITS-1:0]   inv_way_s;
  logic [WAY_BITS-1:0]   lru_way_s;
  logic [WAY_BITS-1:0]   victim_way_s;
  logic [WORD_IDX_W-1:0] wr_word_s;
  logic                  upd_en_s;
  logic [WAY_BITS-1:0]   upd_way_s;

  // Tag compare across all ways; returns {hit, way}. Scanning from the top
  // down lets the lowest matching way overwrite higher ones, so a duplicate
  // tag (illegal state) resolves to the lowest index.
  function automatic logic [WAY_BITS:0] match_way(
    input logic [TAG_WIDTH-1:0] addr_tag,
    input logic [NUM_WAYS-1:0]  vld,
    input logic [TAG_WIDTH-1:0] tags [NUM_WAYS]
  );
    logic [NUM_WAYS-1:0] match;
    logic [WAY_BITS-1:0] way;
    match = '0;
    way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = vld[w] & (tags[w] == addr_tag);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      way = match[w] ? WAY_BITS'(w) : way;
    end
    return {|match, way};
  endfunction

  // Lookup port 1: hit/way/data, data forced to zero on miss
  always_comb begin
    {rd_hit_s, rd_way_s} = match_way(bus.rdAddr[ADDR_WIDTH-1:TAG_LSB], valid_r, tag_r);
    rd_data_s = rd_hit_s ? data_r[rd_way_s][bus.rdAddr[CACHE_LINE_WIDTH-1:2]] : 32'h0000_0000;
  end

  // Lookup port 2: identical to port 1 on its own address
  always_comb begin
    {rd2_hit_s, rd2_way_s} = match_way(bus.rd2Addr[ADDR_WIDTH-1:TAG_LSB], valid_r, tag_r);
    rd2_data_s = rd2_hit_s ? data_r[rd2_way_s][bus.rd2Addr[CACHE_LINE_WIDTH-1:2]] : 32'h0000_0000;
  end

  // Victim: lowest invalid way if any, otherwise the oldest (max age) way
  always_comb begin
    inv_way_s = '0;
    lru_way_s = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      inv_way_s = valid_r[w] ? inv_way_s : WAY_BITS'(w);
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      lru_way_s = (age_r[w] == WAY_BITS'(NUM_WAYS - 1)) ? WAY_BITS'(w) : lru_way_s;
    end
    victim_way_s = (&valid_r) ? lru_way_s : inv_way_s;
  end

  // Write word index and LRU update source (write beats touch)
  always_comb begin
    wr_word_s = bus.wrOff[CACHE_LINE_WIDTH-1:2];
    upd_en_s  = bus.write | bus.touch;
    upd_way_s = bus.write ? bus.wrWay : bus.touchWay;
  end

  // Drive interface outputs from the combinational views
  always_comb begin
    bus.rdHit       = rd_hit_s;
    bus.rdWay       = rd_way_s;
    bus.rdData      = rd_data_s;
    bus.rd2Hit      = rd2_hit_s;
    bus.rd2Way      = rd2_way_s;
    bus.rd2Data     = rd2_data_s;
    bus.victimWay   = victim_way_s;
    bus.victimValid = valid_r[victim_way_s];
    bus.victimDirty = dirty_r[victim_way_s];
    bus.victimTag   = tag_r[victim_way_s];
    bus.lkupData    = data_r[bus.wrWay][wr_word_s];
  end

  // Set state: reset, invalidate, write and LRU ageing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      dirty_r <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        tag_r[w] <= '0;
        age_r[w] <= WAY_BITS'(w);
        for (int i = 0; i < NUM_WORDS; i++) begin
          data_r[w][i] <= 32'h0000_0000;
        end
      end
    end else if (bus.inval) begin
      // Tags and words survive an invalidate; only flags and ages reset.
      valid_r <= '0;
      dirty_r <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        age_r[w] <= WAY_BITS'(w);
      end
    end else begin
      if (bus.write) begin
        tag_r[bus.wrWay]   <= bus.wrTag;
        valid_r[bus.wrWay] <= bus.wrValid;
        dirty_r[bus.wrWay] <= bus.wrDirty;
        for (int b = 0; b < 4; b++) begin
          if (bus.wrByteEnable[b]) begin
            data_r[bus.wrWay][wr_word_s][8*b +: 8] <= bus.wrData[8*b +: 8];
          end
        end
      end
      // Move the accessed way to age 0; only ways younger than it age by
      // one, which keeps the ages a permutation of 0..NUM_WAYS-1.
      if (upd_en_s) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_BITS'(w) == upd_way_s) begin
            age_r[w] <= '0;
          end else if (age_r[w] < age_r[upd_way_s]) begin
            age_r[w] <= age_r[w] + WAY_BITS'(1);
          end
        end
      end
    end
  end

  // Address bits not used by this set (index bits and byte-in-word bits)
  logic unused_s;
  always_comb begin
    unused_s = ^{bus.rdAddr[TAG_LSB-1:CACHE_LINE_WIDTH], bus.rdAddr[1:0],
                 bus.rd2Addr[TAG_LSB-1:CACHE_LINE_WIDTH], bus.rd2Addr[1:0],
                 bus.wrOff[1:0]};
  end

endmodule
